// File: rtl/aes_sched_pkg.sv
// Shared types and widths for the two-requester AES core scheduler.
package aes_sched_pkg;

    localparam int AES_W  = 128;
    localparam int WAIT_W = 8;   // holds KLD_WAIT up to 255
    localparam int WDOG_W = 10;  // holds TIMEOUT-1 up to 1022

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KWAIT,
        S_TLOAD,
        S_BUSY,
        S_RESP
    } sched_state_t;

    typedef struct packed {
        logic             mode;
        logic [AES_W-1:0] key;
        logic [AES_W-1:0] text;
    } aes_job_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the requester named by upd_id.
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       gnt_valid,
    output logic       gnt_id
);
    logic ptr_reg;

    assign gnt_valid = |req;
    // Favoured requester wins a tie; otherwise whoever is asking.
    assign gnt_id    = req[ptr_reg] ? ptr_reg : ~ptr_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= 1'b0;
        end else if (upd) begin
            ptr_reg <= ~upd_id;
        end
    end

endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES core between two requesters, skipping key expansion when the
// cached key and mode match, and turning a missing done into an error response.
module aes_core_sched
    import aes_sched_pkg::*;
#(
    parameter int KLD_WAIT = 12,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [AES_W-1:0] req0_key,
    input  logic [AES_W-1:0] req0_text,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [AES_W-1:0] req1_key,
    input  logic [AES_W-1:0] req1_text,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [AES_W-1:0] rsp_text,
    output logic             rsp_err,
    input  logic             key_flush,
    output logic             aes_mode,
    output logic             aes_kld,
    output logic             aes_ld,
    output logic [AES_W-1:0] aes_key,
    output logic [AES_W-1:0] aes_text_in,
    input  logic             aes_done,
    input  logic [AES_W-1:0] aes_text_out
);
    sched_state_t      state_reg;
    aes_job_t          job_reg;
    logic              gnt_id_reg;
    logic              cache_valid_reg;
    logic              cache_mode_reg;
    logic [AES_W-1:0]  cache_key_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WDOG_W-1:0] wdog_reg;
    logic              aes_kld_reg;
    logic              aes_ld_reg;
    logic              rsp0_valid_reg;
    logic              rsp1_valid_reg;
    logic [AES_W-1:0]  rsp_text_reg;
    logic              rsp_err_reg;

    logic     gnt_valid;
    logic     gnt_id;
    logic     grant;
    logic     cache_hit;
    logic     rsp_hs;
    aes_job_t req_job;

    aes_rr_arb2 u_arb (
        .clk       (clk),
        .srst      (rst),
        .req       ({req1_valid, req0_valid}),
        .upd       (rsp_hs),
        .upd_id    (gnt_id_reg),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign req_job   = gnt_id ? {req1_mode, req1_key, req1_text}
                              : {req0_mode, req0_key, req0_text};
    // Ready is held low during reset so every output reads 0 while rst is high.
    assign grant      = (state_reg == S_IDLE) && gnt_valid && !rst;
    assign req0_ready = grant && !gnt_id;
    assign req1_ready = grant && gnt_id;
    assign cache_hit  = cache_valid_reg && (cache_key_reg == req_job.key)
                        && (cache_mode_reg == req_job.mode);
    assign rsp_hs     = (state_reg == S_RESP) && (gnt_id_reg ? rsp1_ready : rsp0_ready);

    assign aes_mode    = job_reg.mode;
    assign aes_key     = job_reg.key;
    assign aes_text_in = job_reg.text;
    assign aes_kld     = aes_kld_reg;
    assign aes_ld      = aes_ld_reg;
    assign rsp0_valid  = rsp0_valid_reg;
    assign rsp1_valid  = rsp1_valid_reg;
    assign rsp_text    = rsp_text_reg;
    assign rsp_err     = rsp_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            job_reg         <= '0;
            gnt_id_reg      <= 1'b0;
            cache_valid_reg <= 1'b0;
            cache_mode_reg  <= 1'b0;
            cache_key_reg   <= '0;
            wait_cnt_reg    <= '0;
            wdog_reg        <= '0;
            aes_kld_reg     <= 1'b0;
            aes_ld_reg      <= 1'b0;
            rsp0_valid_reg  <= 1'b0;
            rsp1_valid_reg  <= 1'b0;
            rsp_text_reg    <= '0;
            rsp_err_reg     <= 1'b0;
        end else begin
            aes_kld_reg <= 1'b0;
            aes_ld_reg  <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    if (grant) begin
                        job_reg    <= req_job;
                        gnt_id_reg <= gnt_id;
                        if (cache_hit) begin
                            state_reg  <= S_TLOAD;
                            aes_ld_reg <= 1'b1;
                        end else begin
                            state_reg   <= S_KLOAD;
                            aes_kld_reg <= 1'b1;
                        end
                    end
                end
                S_KLOAD: begin
                    state_reg    <= S_KWAIT;
                    wait_cnt_reg <= WAIT_W'(KLD_WAIT);
                end
                S_KWAIT: begin
                    // Leaving on the count of 1 gives exactly KLD_WAIT wait cycles.
                    if (wait_cnt_reg == WAIT_W'(1)) begin
                        state_reg       <= S_TLOAD;
                        aes_ld_reg      <= 1'b1;
                        wait_cnt_reg    <= '0;
                        cache_valid_reg <= 1'b1;
                        cache_key_reg   <= job_reg.key;
                        cache_mode_reg  <= job_reg.mode;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                S_TLOAD: begin
                    state_reg <= S_BUSY;
                    wdog_reg  <= '0;
                end
                S_BUSY: begin
                    if (aes_done) begin
                        rsp_text_reg   <= aes_text_out;
                        rsp_err_reg    <= 1'b0;
                        rsp0_valid_reg <= ~gnt_id_reg;
                        rsp1_valid_reg <= gnt_id_reg;
                        state_reg      <= S_RESP;
                    end else if (wdog_reg == WDOG_W'(TIMEOUT - 1)) begin
                        rsp_text_reg    <= '0;
                        rsp_err_reg     <= 1'b1;
                        rsp0_valid_reg  <= ~gnt_id_reg;
                        rsp1_valid_reg  <= gnt_id_reg;
                        cache_valid_reg <= 1'b0;
                        state_reg       <= S_RESP;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid_reg <= 1'b0;
                        rsp1_valid_reg <= 1'b0;
                        state_reg      <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
            // Placed last so a flush overrides the cache write on KWAIT exit.
            if (key_flush) begin
                cache_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched with a behavioural AES core stand-in.
module tb_aes_core_sched;

    localparam int KW = 12;
    localparam int TO = 64;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req0_ready, req0_mode = 1'b0;
    logic [127:0] req0_key = '0, req0_text = '0;
    logic         req1_valid = 1'b0, req1_ready, req1_mode = 1'b0;
    logic [127:0] req1_key = '0, req1_text = '0;
    logic         rsp0_valid, rsp0_ready = 1'b0;
    logic         rsp1_valid, rsp1_ready = 1'b0;
    logic [127:0] rsp_text;
    logic         rsp_err;
    logic         key_flush = 1'b0;
    logic         aes_mode, aes_kld, aes_ld;
    logic [127:0] aes_key, aes_text_in;
    logic         aes_done = 1'b0;
    logic [127:0] aes_text_out = '0;

    aes_core_sched #(.KLD_WAIT(KW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_key(req0_key), .req0_text(req0_text),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_key(req1_key), .req1_text(req1_text),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_text(rsp_text), .rsp_err(rsp_err), .key_flush(key_flush),
        .aes_mode(aes_mode), .aes_kld(aes_kld), .aes_ld(aes_ld),
        .aes_key(aes_key), .aes_text_in(aes_text_in),
        .aes_done(aes_done), .aes_text_out(aes_text_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Event monitor for the core handshake strobes
    int kld_cnt = 0, kld_cyc = -1, ld_cyc = -1, done_cyc = -1, wrong_rsp = 0;
    always @(negedge clk) begin
        if (aes_kld) begin
            kld_cnt++;
            kld_cyc = cyc;
        end
        if (aes_ld) ld_cyc = cyc;
    end

    // Core stand-in: knows the FIPS-197 vector both ways, inverts anything else
    logic         core_en = 1'b1;
    int           core_lat = 11;
    int           core_cnt = 0;
    bit           core_busy = 1'b0;
    logic         core_mode = 1'b0;
    logic [127:0] core_key = '0, core_text = '0;

    function automatic logic [127:0] core_result(input logic m, input logic [127:0] k,
                                                 input logic [127:0] t);
        if (k == KEY && m && t == PT) return CT;
        if (k == KEY && !m && t == CT) return PT;
        return ~t;
    endfunction

    always @(negedge clk) begin
        aes_done = 1'b0;
        if (aes_ld && core_en) begin
            core_busy = 1'b1;
            core_cnt  = core_lat;
            core_mode = aes_mode;
            core_key  = aes_key;
            core_text = aes_text_in;
        end else if (core_busy) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_busy    = 1'b0;
                aes_done     = 1'b1;
                aes_text_out = core_result(core_mode, core_key, core_text);
                done_cyc     = cyc;
            end
        end
    end

    task automatic wait_rsp(input int id, output int rcyc, output logic [127:0] rtext,
                            output logic rerr);
        bit got = 1'b0;
        rcyc = -1; rtext = 'x; rerr = 1'bx;
        for (int i = 0; i < 300; i++) begin
            if ((id == 0 && rsp1_valid) || (id == 1 && rsp0_valid)) wrong_rsp++;
            if (id == 0 ? rsp0_valid : rsp1_valid) begin
                got = 1'b1; rcyc = cyc; rtext = rsp_text; rerr = rsp_err;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk_eq("rsp_wait", 128'(0), 128'(1));
        end else begin
            if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            @(negedge clk);
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        end
    endtask

    task automatic wait_grant(input int id, output int gcyc);
        bit got = 1'b0;
        gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (id == 0 ? req0_ready : req1_ready) begin
                got = 1'b1; gcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk_eq("grant_wait", 128'(0), 128'(1));
        @(negedge clk);
    endtask

    task automatic run_job(input int id, input logic mode, input logic [127:0] key,
                           input logic [127:0] text, output int gcyc, output int rcyc,
                           output logic [127:0] rtext, output logic rerr);
        kld_cnt = 0;
        if (id == 0) begin
            req0_mode = mode; req0_key = key; req0_text = text; req0_valid = 1'b1;
        end else begin
            req1_mode = mode; req1_key = key; req1_text = text; req1_valid = 1'b1;
        end
        wait_grant(id, gcyc);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(id, rcyc, rtext, rerr);
        $display("job req%0d mode=%0d grant@%0d rsp@%0d kld=%0d text=%h err=%0d",
                 id, mode, gcyc, rcyc, kld_cnt, rtext, rerr);
    endtask

    int           g, r, rr_id, stray;
    logic [127:0] t;
    logic         e;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("rst_kld", 128'(aes_kld), 128'(0));
        chk_eq("rst_ld", 128'(aes_ld), 128'(0));
        chk_eq("rst_key", aes_key, 128'(0));
        chk_eq("rst_rsp_valid", 128'({rsp1_valid, rsp0_valid}), 128'(0));
        chk_eq("rst_rsp_text", rsp_text, 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Miss path from reset
        run_job(0, 1'b1, KEY, PT, g, r, t, e);
        chk_eq("miss_kld_cnt", 128'(kld_cnt), 128'(1));
        chk_eq("miss_kld_at", 128'(kld_cyc), 128'(g + 1));
        chk_eq("miss_ld_gap", 128'(ld_cyc - kld_cyc), 128'(KW + 1));
        chk_eq("miss_text", t, CT);
        chk_eq("miss_err", 128'(e), 128'(0));
        chk_eq("miss_rsp_lat", 128'(r), 128'(done_cyc + 1));
        chk_eq("miss_rsp_drop", 128'(rsp0_valid), 128'(0));

        // Cache hit
        run_job(0, 1'b1, KEY, PT, g, r, t, e);
        chk_eq("hit_kld_cnt", 128'(kld_cnt), 128'(0));
        chk_eq("hit_ld_at", 128'(ld_cyc), 128'(g + 1));
        chk_eq("hit_text", t, CT);

        // Mode change on requester 1
        run_job(1, 1'b0, KEY, CT, g, r, t, e);
        chk_eq("mode_kld_cnt", 128'(kld_cnt), 128'(1));
        chk_eq("mode_text", t, PT);

        // Round-robin with both requesters held valid
        req0_mode = 1'b1; req0_key = KEY; req0_text = PT; req0_valid = 1'b1;
        req1_mode = 1'b0; req1_key = KEY; req1_text = CT; req1_valid = 1'b1;
        wrong_rsp = 0;
        for (int j = 0; j < 4; j++) begin
            rr_id = -1;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    rr_id = req1_ready ? 1 : 0;
                    break;
                end
                @(negedge clk);
            end
            chk_eq($sformatf("rr_order_%0d", j), 128'(rr_id), 128'(j % 2));
            @(negedge clk);
            wait_rsp(rr_id < 0 ? 0 : rr_id, r, t, e);
            chk_eq($sformatf("rr_text_%0d", j), t, (j % 2 == 0) ? CT : PT);
            $display("job rr%0d req%0d rsp@%0d text=%h err=%0d", j, rr_id, r, t, e);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk_eq("rr_wrong_rsp", 128'(wrong_rsp), 128'(0));

        // Timeout: core never answers
        core_en = 1'b0;
        run_job(0, 1'b1, KEY, PT, g, r, t, e);
        chk_eq("to_err", 128'(e), 128'(1));
        chk_eq("to_text", t, 128'(0));
        chk_eq("to_rsp_at", 128'(r), 128'(ld_cyc + TO + 1));
        core_en = 1'b1;
        run_job(0, 1'b1, KEY, PT, g, r, t, e);
        chk_eq("to_next_kld", 128'(kld_cnt), 128'(1));
        chk_eq("to_next_text", t, CT);

        // Reset while BUSY; the late done must not produce anything
        req0_mode = 1'b1; req0_key = KEY; req0_text = PT; req0_valid = 1'b1;
        wait_grant(0, g);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mrst_core_if", {aes_key ^ aes_text_in}, 128'(0));
        chk_eq("mrst_strobes", 128'({aes_mode, aes_kld, aes_ld, rsp0_valid, rsp1_valid, rsp_err}),
               128'(0));
        chk_eq("mrst_rsp_text", rsp_text, 128'(0));
        rst = 1'b0;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || aes_ld || aes_kld) stray++;
        end
        chk_eq("mrst_late_done", 128'(stray), 128'(0));
        chk_eq("mrst_late_text", rsp_text, 128'(0));
        $display("job mid-reset req0 grant@%0d aborted, stray=%0d", g, stray);
        run_job(0, 1'b1, KEY, PT, g, r, t, e);
        chk_eq("mrst_next_kld", 128'(kld_cnt), 128'(1));
        chk_eq("mrst_next_text", t, CT);

        // Flush in IDLE forces a reload of the same key
        key_flush = 1'b1;
        @(negedge clk);
        key_flush = 1'b0;
        run_job(0, 1'b1, KEY, PT, g, r, t, e);
        chk_eq("flush_kld", 128'(kld_cnt), 128'(1));
        chk_eq("flush_text", t, CT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_core_sched.md
Name: aes_core_sched

Overview:
- Two-requester scheduler that shares one AES core (mode/kld/ld/key/text_in in, done/text_out out) between requesters.
- Round-robin arbitration; caches the last loaded key+mode so kld is skipped on a hit.
- Sequences the core's kld → ld → done handshakes and returns each result to its requester.
- Watchdog turns a missing done into an error response.
- Sits between the system request fabric and the AES core instance.

Parameters:
- KLD_WAIT, 12, idle cycles after the aes_kld pulse before aes_ld is allowed (key expansion time); range 1..255.
- TIMEOUT, 64, maximum BUSY cycles awaiting aes_done before an error response; range 2..1023.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  job accepted (one-cycle pulse).
- req0_mode  in  1  1=encrypt, 0=decrypt.
- req0_key  in  128  key.
- req0_text  in  128  input block.
- req1_valid, req1_ready, req1_mode, req1_key, req1_text: as for requester 0.
- rsp0_valid  out  1  response for requester 0.
- rsp0_ready  in  1  requester 0 accepts the response.
- rsp1_valid  out  1  response for requester 1.
- rsp1_ready  in  1  requester 1 accepts the response.
- rsp_text  out  128  result block (shared by both response channels).
- rsp_err  out  1  1 = timeout, rsp_text is 0.
- key_flush  in  1  invalidate the key cache.
- aes_mode  out  1  to core mode.
- aes_kld  out  1  to core kld.
- aes_ld  out  1  to core ld.
- aes_key  out  128  to core key.
- aes_text_in  out  128  to core text_in.
- aes_done  in  1  from core done.
- aes_text_out  in  128  from core text_out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE; all outputs 0.
  - Key cache invalid; round-robin pointer favours requester 0; counters cleared.
  - Reset mid-operation aborts the job and drops any pending response.
  - A core still running is ignored; its done is discarded because the state is not BUSY.
- States: IDLE, KLOAD, KWAIT, TLOAD, BUSY, RESP.
- IDLE:
  - If any reqN_valid, grant per round-robin: the favoured requester wins a tie, and the other requester becomes favoured after the job completes.
  - reqN_ready=1 for that single cycle; latch mode, key, text and grant id.
  - Next state is TLOAD if the cache is valid and the cached key and mode equal the latched ones; otherwise KLOAD.
- KLOAD:
  - aes_kld=1 for exactly one cycle.
  - Next state KWAIT; load the wait counter with KLD_WAIT.
- KWAIT:
  - Decrement each cycle; at 0, go to TLOAD.
  - The cache is marked valid with the latched key and mode on KWAIT exit.
- TLOAD:
  - aes_ld=1 for exactly one cycle.
  - Next state BUSY; clear the watchdog.
- aes_key, aes_mode and aes_text_in are driven from the latched job registers and are stable from KLOAD/TLOAD through BUSY. Outside a job they hold their last values (0 after reset).
- BUSY:
  - On aes_done=1: capture aes_text_out into rsp_text, rsp_err=0, go to RESP.
  - Else, when the watchdog reaches TIMEOUT: rsp_text=0, rsp_err=1, invalidate the cache, go to RESP.
  - If done and the watchdog limit coincide, done wins.
- RESP:
  - rspN_valid=1 for the granted id only; rsp_text and rsp_err held stable.
  - On rspN_ready=1, drop valid next cycle, update the round-robin pointer, go to IDLE.
  - No grant in the handshake cycle (one-cycle bubble).
- aes_done outside BUSY is ignored.
- key_flush:
  - Clears cache-valid at the next edge in any state.
  - If flush coincides with the KWAIT-exit cache write, flush wins (cache invalid).
- Latency (grant cycle = T, aes_done sampled high at cycle D):
  - Cache hit: aes_ld at T+1, rsp valid at D+1.
  - Cache miss: aes_kld at T+1, aes_ld at T+2+KLD_WAIT.
  - Minimum issue interval is two cycles beyond the response handshake.
- Only one job is in flight; a requester's valid stays unacknowledged while the other is served.

Decomposition:
- Package aes_sched_pkg:
  - AES_W=128.
  - State enum sched_state_t.
  - Packed struct aes_job_t {mode, key, text}.
  - Widths for the wait and watchdog counters, derived from parameter maxima (8 and 10 bits).
- Sub-module aes_rr_arb2: two-input round-robin arbiter with a pointer-update strobe; the rest stays in aes_core_sched.

Test Plan:
- Miss path: from reset, req0 encrypt, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, core model done after 11 cycles. Required:
  - one aes_kld pulse;
  - aes_ld exactly KLD_WAIT+1 cycles after it;
  - rsp0_valid, rsp_text=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- Cache hit: second req0 with the same key and mode → no aes_kld; aes_ld one cycle after grant; correct ciphertext.
- Round-robin: req0 and req1 held valid continuously for 4 jobs → grant order 0,1,0,1; rsp1_valid never asserted for a requester-0 job.
- Mode change: same key, mode=0, text 69c4e0d86a7b0430d8cdb78070b4c55a → aes_kld reissued; rsp_text=00112233445566778899aabbccddeeff.
- Timeout: core never asserts done → rsp_err=1 and rsp_text=0 after TIMEOUT BUSY cycles; the next job with the same key reissues aes_kld.
- Mid-job reset and flush:
  - rst pulsed in BUSY → all outputs 0 next cycle; a late aes_done is ignored; the next job reissues aes_kld.
  - key_flush in IDLE → the next same-key job reissues aes_kld.
